// File: rtl/maze_pkg.sv
// Shared constants and enumerations for the 17x17 maze checker.
package maze_pkg;
  localparam int N      = 17;
  localparam int CELLS  = N * N;
  localparam int GOAL   = CELLS - 1;
  localparam int STEP_W = 16;

  // Sized copies so comparisons against 9/12-bit registers stay width-clean.
  localparam logic [8:0]  N9        = 9'd17;
  localparam logic [8:0]  CELLS9    = 9'd289;
  localparam logic [8:0]  GOAL9     = 9'd288;
  localparam logic [11:0] TIMEOUT12 = 12'd3000;

  typedef enum logic [1:0] {RIGHT, DOWN, LEFT, UP} dir_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_WALL       = 3'd1,
    ERR_BOUND      = 3'd2,
    ERR_TIMEOUT    = 3'd3,
    ERR_INCOMPLETE = 3'd4,
    ERR_OVERRUN    = 3'd5,
    ERR_PROTOCOL   = 3'd6
  } err_e;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, WALK, FIN} state_e;
endpackage

// File: rtl/maze_step_calc.sv
// Next-cell computation for one move; edge detection uses compares against
// multiples of N so no divider is needed.
module maze_step_calc
  import maze_pkg::*;
(
  input  logic [8:0] pos,
  input  logic [1:0] dir,
  output logic [8:0] next_pos,
  output logic       out_of_bound
);

  logic col_first;
  logic col_last;
  logic row_first;
  logic row_last;

  always_comb begin
    col_first = 1'b0;
    col_last  = 1'b0;
    for (int r = 0; r < N; r++) begin
      if (pos == 9'(r * N))         col_first = 1'b1;
      if (pos == 9'(r * N + N - 1)) col_last  = 1'b1;
    end
  end

  assign row_first = (pos < N9);
  assign row_last  = (pos >= CELLS9 - N9);

  always_comb begin
    next_pos     = pos;
    out_of_bound = 1'b0;
    case (dir_e'(dir))
      RIGHT: begin next_pos = pos + 9'd1; out_of_bound = col_last;  end
      DOWN:  begin next_pos = pos + N9;   out_of_bound = row_last;  end
      LEFT:  begin next_pos = pos - 9'd1; out_of_bound = col_first; end
      UP:    begin next_pos = pos - N9;   out_of_bound = row_first; end
      default: begin next_pos = pos; out_of_bound = 1'b1; end
    endcase
  end

endmodule

// File: rtl/maze_walk_checker.sv
// Streams a stored maze to the solver, then replays its direction stream and
// reports the first error, pass/fail and number of accepted beats.
module maze_walk_checker
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [8:0]        cfg_addr,
  input  logic              cfg_bit,
  input  logic              start,
  output logic              busy,
  output logic              maze_valid,
  output logic              maze_bit,
  input  logic              dir_valid,
  input  logic [1:0]        dir,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [STEP_W-1:0] step_cnt
);

  state_e             state_q, state_d;
  logic [CELLS-1:0]   maze_q, maze_d;
  logic [8:0]         scnt_q, scnt_d;
  logic [11:0]        tcnt_q, tcnt_d;
  logic [8:0]         pos_q, pos_d;
  err_e               err_q, err_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               busy_q, busy_d;
  logic               mvalid_q, mvalid_d;
  logic               mbit_q, mbit_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [8:0] next_pos;
  logic       out_of_bound;
  logic       fin_now;

  maze_step_calc u_step (
    .pos          (pos_q),
    .dir          (dir),
    .next_pos     (next_pos),
    .out_of_bound (out_of_bound)
  );

  always_comb begin
    state_d  = state_q;
    maze_d   = maze_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    pos_d    = pos_q;
    err_d    = err_q;
    step_d   = step_q;
    busy_d   = busy_q;
    mvalid_d = mvalid_q;
    mbit_d   = mbit_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    fin_now  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_we && (cfg_addr < CELLS9)) maze_d[cfg_addr] = cfg_bit;
        if (start) begin
          state_d  = SEND;
          busy_d   = 1'b1;
          mvalid_d = 1'b1;
          mbit_d   = maze_q[0];
          scnt_d   = 9'd1;
          tcnt_d   = '0;
          pos_d    = '0;
          err_d    = ERR_NONE;
          step_d   = '0;
          pass_d   = 1'b0;
        end
      end
      SEND: begin
        if (dir_valid && (err_q == ERR_NONE)) err_d = ERR_PROTOCOL;
        if (scnt_q == CELLS9) begin
          mvalid_d = 1'b0;
          mbit_d   = 1'b0;
          state_d  = WAIT;
        end else begin
          mbit_d = maze_q[scnt_q];
          scnt_d = scnt_q + 9'd1;
        end
      end
      WAIT, WALK: begin
        if (dir_valid) begin
          state_d = WALK;
          step_d  = (&step_q) ? step_q : step_q + 1'b1;
          // Once any error is latched the position freezes; beats are still counted.
          if (err_q == ERR_NONE) begin
            if (pos_q == GOAL9)         err_d = ERR_OVERRUN;
            else if (out_of_bound)      err_d = ERR_BOUND;
            else if (!maze_q[next_pos]) err_d = ERR_WALL;
            else                        pos_d = next_pos;
          end
        end else if (state_q == WAIT) begin
          if (tcnt_q == TIMEOUT12 - 12'd1) begin
            if (err_q == ERR_NONE) err_d = ERR_TIMEOUT;
            fin_now = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 12'd1;
          end
        end else begin
          if ((err_q == ERR_NONE) && (pos_q != GOAL9)) err_d = ERR_INCOMPLETE;
          fin_now = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin_now) begin
      state_d = FIN;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      pass_d  = (err_d == ERR_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      maze_q   <= '0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      pos_q    <= '0;
      err_q    <= ERR_NONE;
      step_q   <= '0;
      busy_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mbit_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      maze_q   <= maze_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      mvalid_q <= mvalid_d;
      mbit_q   <= mbit_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign maze_valid = mvalid_q;
  assign maze_bit   = mbit_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_code   = err_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_maze_walk_checker.sv
// Directed and random runs of the maze checker against a row/column walk model.
module tb_maze_walk_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [8:0]  cfg_addr;
  logic        cfg_bit;
  logic        start;
  logic        busy;
  logic        maze_valid;
  logic        maze_bit;
  logic        dir_valid;
  logic [1:0]  dir;
  logic        done;
  logic        pass;
  logic [2:0]  err_code;
  logic [15:0] step_cnt;

  int checks = 0;
  int errors = 0;
  bit mz[289];

  always #5 clk = ~clk;

  maze_walk_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_bit    (cfg_bit),
    .start      (start),
    .busy       (busy),
    .maze_valid (maze_valid),
    .maze_bit   (maze_bit),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .done       (done),
    .pass       (pass),
    .err_code   (err_code),
    .step_cnt   (step_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk the grid in (row, col) terms; first error wins.
  function automatic void model(input int dirs[$], input bit proto,
                                output int err, output int steps);
    int r, c, nr, nc;
    r = 0; c = 0;
    err = proto ? 6 : 0;
    steps = (dirs.size() > 65535) ? 65535 : dirs.size();
    foreach (dirs[i]) begin
      if (err == 0) begin
        nr = r; nc = c;
        case (dirs[i])
          0: nc = c + 1;
          1: nr = r + 1;
          2: nc = c - 1;
          default: nr = r - 1;
        endcase
        if (r == 16 && c == 16)                          err = 5;
        else if (nr < 0 || nr > 16 || nc < 0 || nc > 16) err = 2;
        else if (!mz[nr * 17 + nc])                      err = 1;
        else begin r = nr; c = nc; end
      end
    end
    if (dirs.size() == 0) begin
      if (err == 0) err = 3;
    end else if (err == 0 && !(r == 16 && c == 16)) begin
      err = 4;
    end
  endfunction

  task automatic load_maze();
    @(negedge clk);
    cfg_we = 1'b1;
    for (int i = 0; i < 289; i++) begin
      cfg_addr = 9'(i);
      cfg_bit  = mz[i];
      @(negedge clk);
    end
    cfg_addr = 9'd300;
    cfg_bit  = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run(input string tag, input int dirs[$], input bit proto);
    int exp_err, exp_steps, good, waits;
    model(dirs, proto, exp_err, exp_steps);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    good = 0;
    for (int k = 0; k < 289; k++) begin
      if (maze_valid === 1'b1 && maze_bit === mz[k]) good++;
      dir_valid = proto && (k == 100);
      dir       = 2'd0;
      start     = proto && (k == 50);
      @(negedge clk);
    end
    dir_valid = 1'b0;
    start     = 1'b0;
    check({tag, " stream_beats_ok"}, good, 289);
    check({tag, " stream_ends"}, maze_valid, 0);
    foreach (dirs[i]) begin
      dir_valid = 1'b1;
      dir       = 2'(dirs[i]);
      @(negedge clk);
    end
    dir_valid = 1'b0;
    waits = 0;
    while (done !== 1'b1 && waits < 4000) begin
      @(negedge clk);
      waits++;
    end
    check({tag, " done_seen"}, done, 1);
    if (dirs.size() == 0) check({tag, " timeout_window"}, (waits >= 2999 && waits <= 3001), 1);
    else                  check({tag, " done_latency"}, waits, 1);
    check({tag, " err_code"}, err_code, exp_err);
    check({tag, " pass"}, pass, (exp_err == 0));
    check({tag, " step_cnt"}, step_cnt, exp_steps);
    check({tag, " busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
  endtask

  task automatic path_maze();
    foreach (mz[i]) mz[i] = 1'b0;
    for (int c = 0; c < 17; c++) mz[c] = 1'b1;
    for (int r = 0; r < 17; r++) mz[r * 17 + 16] = 1'b1;
  endtask

  initial begin
    int q[$];
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bit = 1'b0;
    start = 1'b0; dir_valid = 1'b0; dir = '0;
    foreach (mz[i]) mz[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset maze_valid", maze_valid, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err_code", err_code, 0);
    check("reset step_cnt", step_cnt, 0);
    rst_n = 1'b1;

    // Cleared RAM streams all zeros; no solver answer -> timeout.
    q = {};
    run("T5_timeout", q, 1'b0);

    path_maze();
    load_maze();
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(0);
    for (int i = 0; i < 16; i++) q.push_back(1);
    run("T1_solve", q, 1'b0);
    q.push_back(0);
    run("T_overrun", q, 1'b0);
    run("T6_protocol", q, 1'b1);
    q = {0, 0, 0, 0, 0};
    run("T5_incomplete", q, 1'b0);
    q = {3};
    run("T4_bound_up", q, 1'b0);
    mz[17] = 1'b1;
    load_maze();
    q = {1, 2};
    run("T4_bound_left", q, 1'b0);

    for (int r = 0; r < 17; r++)
      for (int c = 0; c < 17; c++) mz[r * 17 + c] = ((r + c) % 2 == 0);
    load_maze();
    q = {0, 1, 1};
    run("T3_wall", q, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int len;
      bit biased;
      foreach (mz[i]) mz[i] = ($urandom_range(0, 9) < 7);
      biased = $urandom_range(0, 1);
      if (biased) begin
        for (int c = 0; c < 17; c++) mz[c] = 1'b1;
        for (int r = 0; r < 17; r++) mz[r * 17 + 16] = 1'b1;
      end
      load_maze();
      len = $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(biased ? $urandom_range(0, 1) : $urandom_range(0, 3));
      run($sformatf("RND%0d", n), q, 1'b0);
    end

    // Reset in the middle of a stream returns everything to idle at once.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset maze_valid", maze_valid, 0);
    check("midreset err_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
